// File: rtl/mdu_div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide unit: FSM encodings, iteration
// count and result bus width.
package mdu_div_ctrl_pkg;

  localparam int DIV_W      = 32;
  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/mdu_div_ctrl_div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit and
// subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // A borrow out of the WIDTH+1 bit subtraction means the divisor did not fit.
  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    diff    = shifted - {1'b0, dsr_i};
    q_bit_o = ~diff[WIDTH];
    rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_div_ctrl.sv
// DIV/DIVU sequencer: stalls the pipeline while a restoring divider produces one
// quotient bit per cycle, then pulses done with sign-corrected results.
module mdu_div_ctrl
  import mdu_div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_W,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cancel,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             b_zero;
  logic             last_step;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] q_raw;

  assign accept    = (state_q == DIV_IDLE) && start && !cancel;
  assign b_zero    = (op_b == '0);
  assign last_step = (state_q == DIV_RUN) && (cnt_q == CNT_W'(WIDTH - 1));
  assign a_abs     = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign b_abs     = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  assign q_raw     = {dvd_q[WIDTH-2:0], step_bit};

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .dsr_i     (dsr_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // cancel overrides everything, including a start seen in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (accept) state_d = b_zero ? DIV_DONE : DIV_RUN;
      DIV_RUN:  if (last_step) state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (cancel) state_d = DIV_IDLE;
  end

  // A flushed instruction must not see its done pulse.
  always_comb begin
    stall_req = accept;
    done      = 1'b0;
    case (state_q)
      DIV_RUN:  stall_req = 1'b1;
      DIV_DONE: done      = !cancel;
      default:  ;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    dz_d    = dz_q;
    if (accept) begin
      if (b_zero) begin
        quot_d = '1;
        rmd_d  = op_a;
        dz_d   = 1'b1;
      end else begin
        cnt_d   = '0;
        rem_d   = '0;
        dvd_d   = a_abs;
        dsr_d   = b_abs;
        q_neg_d = is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        r_neg_d = is_signed && op_a[WIDTH-1];
      end
    end else if ((state_q == DIV_RUN) && !cancel) begin
      cnt_d = cnt_q + CNT_W'(1);
      rem_d = step_rem;
      dvd_d = q_raw;
      // Published results only change when an operation actually completes.
      if (last_step) begin
        quot_d = q_neg_q ? -q_raw : q_raw;
        rmd_d  = r_neg_q ? -step_rem : step_rem;
        dz_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quot_q  <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
      dz_q    <= dz_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rmd_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// Self-checking bench for mdu_div_ctrl: vector table, randomized operations
// against an arithmetic reference, and hand-written cancel/reset/back-to-back cases.
module tb_mdu_div_ctrl;
  import mdu_div_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        cancel;
  logic        stall_req;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

  logic [31:0] last_q, last_r;
  logic        last_dz;

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    bit          dz;
  } vec_t;

  vec_t vecs[8];

  mdu_div_ctrl #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .cancel    (cancel),
    .stall_req (stall_req),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] q, input logic [31:0] r,
                             input bit dz);
    check32({name, " quotient"}, quotient, q);
    check32({name, " remainder"}, remainder, r);
    check32({name, " div_zero"}, {31'd0, div_zero}, {31'd0, dz});
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one start request and returns just after the edge that sampled it.
  task automatic applyStimulus(input bit s, input logic [31:0] a, input logic [31:0] b);
    is_signed = s;
    op_a      = a;
    op_b      = b;
    start     = 1'b1;
    stepCycle();
    start = 1'b0;
    #1;
  endtask

  // Counts edges until done (-1 on timeout) and tallies stall_req deviations.
  task automatic waitDone(input int limit, input bit exp_stall, output int lat,
                          output int stall_bad);
    lat       = -1;
    stall_bad = 0;
    for (int k = 0; k <= limit; k++) begin
      if (k > 0) stepCycle();
      if (done) begin
        lat = k;
        break;
      end
      if (stall_req !== exp_stall) stall_bad++;
    end
  endtask

  function automatic void refDiv(input bit s, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r, output bit dz);
    longint sa, sb;
    dz = (b == 0);
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic runOp(input string name, input bit s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                       input bit dz);
    int lat, bad;
    applyStimulus(s, a, b);
    waitDone(40, b != 0, lat, bad);
    checkInt({name, " latency"}, lat, (b != 0) ? DIV_CYCLES : 0);
    checkInt({name, " stall during run"}, bad, 0);
    if (lat >= 0) begin
      checkOutput(name, q, r, dz);
      check32({name, " stall in done"}, {31'd0, stall_req}, 32'd0);
      stepCycle();
      check32({name, " done pulse width"}, {31'd0, done}, 32'd0);
      last_q  = q;
      last_r  = r;
      last_dz = dz;
    end
  endtask

  initial begin
    int          lat, bad;
    logic [31:0] a, b, q, r;
    bit          s, dz;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[3] = '{1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1'b1};
    vecs[4] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[6] = '{1'b1, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF0,  1'b1};
    vecs[7] = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0};

    rst_n     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cancel    = 1'b0;
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 32'd0, 32'd0, 1'b0);
    check32("reset done", {31'd0, done}, 32'd0);
    check32("reset stall_req", {31'd0, stall_req}, 32'd0);
    #2 rst_n = 1'b1;
    last_q  = '0;
    last_r  = '0;
    last_dz = 1'b0;
    stepCycle();

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
            vecs[i].q, vecs[i].r, vecs[i].dz);
    end

    $display("[TB] randomized operations");
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (i % 5 == 1) b = b >> $urandom_range(8, 28);
      refDiv(s, a, b, q, r, dz);
      runOp($sformatf("rand%0d", i), s, a, b, q, r, dz);
    end

    $display("[TB] start pulsed mid-run");
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (5) stepCycle();
    is_signed = 1'b1;
    op_a      = 32'd9;
    op_b      = 32'd2;
    start     = 1'b1;
    stepCycle();
    start = 1'b0;
    #1;
    waitDone(40, 1'b1, lat, bad);
    checkInt("midstart latency", lat, DIV_CYCLES - 6);
    checkInt("midstart stall", bad, 0);
    checkOutput("midstart", 32'd14, 32'd2, 1'b0);
    stepCycle();
    last_q = 32'd14; last_r = 32'd2; last_dz = 1'b0;

    $display("[TB] cancel during run");
    applyStimulus(1'b0, 32'd1000, 32'd3);
    repeat (10) stepCycle();
    checkOutput("hold during run", last_q, last_r, last_dz);
    cancel    = 1'b1;
    start     = 1'b1;
    op_a      = 32'd77;
    op_b      = 32'd5;
    #1;
    check32("stall with cancel in run", {31'd0, stall_req}, 32'd1);
    stepCycle();
    cancel = 1'b0;
    start  = 1'b0;
    #1;
    check32("stall after cancel", {31'd0, stall_req}, 32'd0);
    waitDone(40, 1'b0, lat, bad);
    checkInt("cancel no done", lat, -1);
    checkInt("cancel idle stall", bad, 0);
    checkOutput("after cancel", last_q, last_r, last_dz);
    runOp("post-cancel", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7);
    repeat (10) stepCycle();
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async reset", 32'd0, 32'd0, 1'b0);
    check32("async reset stall", {31'd0, stall_req}, 32'd0);
    check32("async reset done", {31'd0, done}, 32'd0);
    #3 rst_n = 1'b1;
    stepCycle();
    runOp("post-reset", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

    $display("[TB] back-to-back with start held");
    is_signed = 1'b0;
    op_a      = 32'd100;
    op_b      = 32'd7;
    start     = 1'b1;
    stepCycle();
    #1;
    waitDone(40, 1'b1, lat, bad);
    checkInt("b2b first latency", lat, DIV_CYCLES);
    checkInt("b2b first stall", bad, 0);
    checkOutput("b2b first", 32'd14, 32'd2, 1'b0);
    check32("b2b stall in done", {31'd0, stall_req}, 32'd0);
    op_a = 32'd50;
    op_b = 32'd6;
    stepCycle();
    check32("b2b idle done", {31'd0, done}, 32'd0);
    check32("b2b idle stall", {31'd0, stall_req}, 32'd1);
    stepCycle();
    start = 1'b0;
    #1;
    waitDone(40, 1'b1, lat, bad);
    checkInt("b2b second latency", lat, DIV_CYCLES);
    checkInt("b2b second stall", bad, 0);
    checkOutput("b2b second", 32'd8, 32'd2, 1'b0);
    stepCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
